// File: rtl/lfsr_rewind_if.sv
// Request/result handshake bundle for lfsr_rewind.
// master = requester/consumer side, slave = the rewind engine.
interface lfsr_rewind_if #(
  parameter int unsigned RNDSIZE = 6
);
  localparam int unsigned W = RNDSIZE * (RNDSIZE - 1) / 2;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_rnd;
  logic [1:0]   in_probability;
  logic [3:0]   in_steps;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_seed;
  logic         busy;

  modport master (
    output in_valid, in_rnd, in_probability, in_steps, out_ready,
    input  in_ready, out_valid, out_seed, busy
  );

  modport slave (
    input  in_valid, in_rnd, in_probability, in_steps, out_ready,
    output in_ready, out_valid, out_seed, busy
  );
endinterface

// File: rtl/lfsr_rewind.sv
// Rewinds a masked LFSR word by 1..16 inverse rounds, one per clock,
// recovering the seed that produced it.
module lfsr_rewind #(
  parameter int unsigned RNDSIZE = 6
) (
  input  logic         clk,
  input  logic         rst,
  lfsr_rewind_if.slave bus
);
  localparam int unsigned W  = RNDSIZE * (RNDSIZE - 1) / 2;
  localparam int unsigned SH = W - RNDSIZE;
  localparam int unsigned WW = W + 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state;
  logic [W-1:0] x;
  logic [W-1:0] mask;
  logic [3:0]   cnt;
  logic [W-1:0] x_next;

  // (2^(7+p) - 1) << SH, computed wide and truncated to W bits.
  function automatic logic [W-1:0] mask_of(input logic [1:0] p);
    logic [WW-1:0] one_w;
    logic [WW-1:0] t;
    one_w = WW'(1);
    t = ((one_w << (32'd7 + 32'(p))) - one_w) << SH;
    return W'(t);
  endfunction

  // Undo one forward step: strip mask, shift right, rebuild the top bit
  // from the forward taps seed[3], seed[2], seed[0] at their shifted slots.
  function automatic logic [W-1:0] unround(input logic [W-1:0] v,
                                           input logic [W-1:0] m);
    logic [W-1:0] y;
    y = v ^ m;
    return {y[0] ^ y[4] ^ y[3] ^ y[1], y[W-1:1]};
  endfunction

  assign x_next = unround(x, mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      x             <= '0;
      mask          <= '0;
      cnt           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.out_seed  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x            <= bus.in_rnd;
            mask         <= mask_of(bus.in_probability);
            cnt          <= bus.in_steps;
            state        <= RUN;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        RUN: begin
          x <= x_next;
          if (cnt == 4'd0) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_seed  <= x_next;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_rewind.sv
// Directed and model-driven checks for lfsr_rewind at RNDSIZE=4 and default 6.
module tb_lfsr_rewind;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lfsr_rewind_if #(.RNDSIZE(4)) b4 ();
  lfsr_rewind_if #(.RNDSIZE(6)) b6 ();

  lfsr_rewind #(.RNDSIZE(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  lfsr_rewind #(.RNDSIZE(6)) u6 (.clk(clk), .rst(rst), .bus(b6.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Forward LFSR_comb at W=15: shift left, feedback from taps 14,3,2,0, then mask.
  function automatic logic [14:0] fwdn(input logic [14:0] s, input logic [1:0] p, input int k);
    logic [14:0] m;
    logic [14:0] v;
    m = 15'(((32'd1 << (7 + p)) - 32'd1) << 9);
    v = s;
    for (int i = 0; i < k; i++)
      v = {v[13:0], v[14] ^ v[3] ^ v[2] ^ v[0]} ^ m;
    return v;
  endfunction

  function automatic logic rdy(input bit s4);
    return s4 ? b4.in_ready : b6.in_ready;
  endfunction
  function automatic logic ov(input bit s4);
    return s4 ? b4.out_valid : b6.out_valid;
  endfunction
  function automatic logic bsy(input bit s4);
    return s4 ? b4.busy : b6.busy;
  endfunction
  function automatic logic [14:0] seed(input bit s4);
    return s4 ? {9'd0, b4.out_seed} : b6.out_seed;
  endfunction

  task automatic set_in(input bit s4, input logic v, input logic [14:0] rnd,
                        input logic [1:0] p, input logic [3:0] st);
    if (s4) begin
      b4.in_valid = v; b4.in_rnd = rnd[5:0]; b4.in_probability = p; b4.in_steps = st;
    end else begin
      b6.in_valid = v; b6.in_rnd = rnd; b6.in_probability = p; b6.in_steps = st;
    end
  endtask

  task automatic set_or(input bit s4, input logic v);
    if (s4) b4.out_ready = v;
    else    b6.out_ready = v;
  endtask

  // Drive one request; returns #1 after the accept edge.
  task automatic req(input bit s4, input logic [14:0] rnd, input logic [1:0] p,
                     input logic [3:0] st, input string tag);
    int w = 0;
    while (!rdy(s4) && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check({tag, "_rdy"}, 32'(rdy(s4)), 32'd1);
    set_in(s4, 1'b1, rnd, p, st);
    @(posedge clk); #1;
    set_in(s4, 1'b0, '0, '0, '0);
    check({tag, "_acc"}, 32'(bsy(s4)), 32'd1);
  endtask

  // Accept cycle is cycle 0; out_valid must first appear in cycle steps+2.
  task automatic wait_done(input bit s4, input logic [3:0] st, input logic [14:0] exp,
                           input string tag);
    int cyc = 1;
    while (!ov(s4) && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(int'(st) + 2));
    check({tag, "_seed"}, 32'(seed(s4)), 32'(exp));
  endtask

  task automatic take(input bit s4, input string tag);
    set_or(s4, 1'b1);
    @(posedge clk); #1;
    set_or(s4, 1'b0);
    check({tag, "_ovclr"}, 32'(ov(s4)), 32'd0);
    check({tag, "_rdyret"}, 32'(rdy(s4)), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [14:0] s, s2, x, x2;
    logic [1:0]  p;
    int          k;
    int          cyc;
    bit          late;

    rst = 1'b1;
    set_in(1'b1, 1'b0, '0, '0, '0);
    set_in(1'b0, 1'b0, '0, '0, '0);
    set_or(1'b1, 1'b0);
    set_or(1'b0, 1'b0);
    #2;
    check("rst_rdy",  32'(b6.in_ready),  32'd1);
    check("rst_ov",   32'(b6.out_valid), 32'd0);
    check("rst_busy", 32'(b6.busy),      32'd0);
    check("rst_seed", 32'(b6.out_seed),  32'd0);
    check("rst_rdy4", 32'(b4.in_ready),  32'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // RNDSIZE=4, mask 0x3C: hand-computed single and double rounds
    req(1'b1, 15'h3F, 2'd0, 4'd0, "t1");
    wait_done(1'b1, 4'd0, 15'h01, "t1");
    take(1'b1, "t1");
    req(1'b1, 15'h02, 2'd2, 4'd1, "t2");
    wait_done(1'b1, 4'd1, 15'h01, "t2");
    take(1'b1, "t2");

    // W=15, mask is 0x7E00 for every p
    req(1'b0, 15'h7E00, 2'd3, 4'd0, "t3");
    wait_done(1'b0, 4'd0, 15'h0000, "t3");
    take(1'b0, "t3");
    req(1'b0, 15'h7E01, 2'd1, 4'd0, "t4");
    wait_done(1'b0, 4'd0, 15'h4000, "t4");
    take(1'b0, "t4");

    // Maximum round count: 16 rounds
    s = 15'h2B5D;
    req(1'b0, fwdn(s, 2'd2, 16), 2'd2, 4'd15, "t16");
    wait_done(1'b0, 4'd15, s, "t16");
    take(1'b0, "t16");

    for (int it = 0; it < 1000; it++) begin
      s = 15'($urandom);
      p = 2'($urandom);
      k = int'($urandom_range(16, 1));
      req(1'b0, fwdn(s, p, k), p, 4'(k - 1), "rnd");
      wait_done(1'b0, 4'(k - 1), s, "rnd");
      take(1'b0, "rnd");
    end

    // Backpressure with a second request held pending
    s = 15'h5A3C; s2 = 15'h1234;
    req(1'b0, fwdn(s, 2'd0, 4), 2'd0, 4'd3, "bp");
    wait_done(1'b0, 4'd3, s, "bp");
    set_in(1'b0, 1'b1, fwdn(s2, 2'd1, 3), 2'd1, 4'd2);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_ov",   32'(b6.out_valid), 32'd1);
      check("bp_hold_seed", 32'(b6.out_seed),  32'(s));
      check("bp_hold_rdy",  32'(b6.in_ready),  32'd0);
    end
    set_or(1'b0, 1'b1);
    @(posedge clk); #1;
    set_or(1'b0, 1'b0);
    check("bp_rel_ov",  32'(b6.out_valid), 32'd0);
    check("bp_rel_rdy", 32'(b6.in_ready),  32'd1);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, '0, '0, '0);
    check("bp2_acc", 32'(b6.busy), 32'd1);
    wait_done(1'b0, 4'd2, s2, "bp2");
    take(1'b0, "bp2");

    // Reset five cycles into a 16-round request
    req(1'b0, fwdn(15'h0F0F, 2'd2, 16), 2'd2, 4'd15, "rs");
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("rs_rdy",  32'(b6.in_ready),  32'd1);
    check("rs_ov",   32'(b6.out_valid), 32'd0);
    check("rs_seed", 32'(b6.out_seed),  32'd0);
    check("rs_busy", 32'(b6.busy),      32'd0);
    @(negedge clk) rst = 1'b0;
    late = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (b6.out_valid) late = 1'b1;
    end
    check("rs_late", 32'(late), 32'd0);
    s = 15'h7001;
    req(1'b0, fwdn(s, 2'd3, 7), 2'd3, 4'd6, "rs2");
    wait_done(1'b0, 4'd6, s, "rs2");
    take(1'b0, "rs2");

    // Back-to-back with out_ready tied high
    s = 15'h3A5B; s2 = 15'h6C01;
    set_or(1'b0, 1'b1);
    req(1'b0, fwdn(s, 2'd1, 4), 2'd1, 4'd3, "bb1");
    set_in(1'b0, 1'b1, fwdn(s2, 2'd0, 2), 2'd0, 4'd1);
    cyc = 1;
    while (!b6.out_valid && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check("bb1_lat",  32'(cyc), 32'd5);
    check("bb1_seed", 32'(b6.out_seed), 32'(s));
    @(posedge clk); #1;
    check("bb_gap_ov",  32'(b6.out_valid), 32'd0);
    check("bb_gap_rdy", 32'(b6.in_ready),  32'd1);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, '0, '0, '0);
    check("bb2_acc", 32'(b6.busy), 32'd1);
    wait_done(1'b0, 4'd1, s2, "bb2");
    @(posedge clk); #1;
    check("bb2_ovclr", 32'(b6.out_valid), 32'd0);
    set_or(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
